// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned multiplier, exact or truncated-approximate per transaction,
// with valid/ready handshake, sideband tag and saturating completion counters.
module approx_mul_pipe #(
  parameter int W       = 8,
  parameter int TRUNC_K = 4,
  parameter int STAGES  = 2,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_mode,
  output logic [31:0]      cnt_total,
  output logic [31:0]      cnt_approx
);

  localparam int PW = 2 * W;
  // Partial-product bits below column TRUNC_K are dropped; COMP is 2^(K-1), or 0 when K = 0.
  localparam logic [PW-1:0] MASK = {PW{1'b1}} << TRUNC_K;
  localparam logic [PW-1:0] COMP = (PW'(1) << TRUNC_K) >> 1;

  logic          adv;
  logic          hs;
  logic [PW-1:0] p_exact;
  logic [PW-1:0] p_approx;
  logic [PW-1:0] p_next;
  logic [PW-1:0] row;

  logic             v_q    [STAGES];
  logic [PW-1:0]    p_q    [STAGES];
  logic [TAG_W-1:0] tag_q  [STAGES];
  logic             mode_q [STAGES];
  logic [31:0]      cnt_total_q;
  logic [31:0]      cnt_approx_q;

  always_comb begin
    p_exact  = PW'(in_a) * PW'(in_b);
    p_approx = '0;
    row      = '0;
    for (int unsigned j = 0; j < W; j++) begin
      row      = in_b[j] ? (PW'(in_a) << j) : '0;
      p_approx = p_approx + (row & MASK);
    end
    if (in_a != '0 && in_b != '0) begin
      p_approx = p_approx + COMP;
    end
    p_next = in_mode ? p_approx : p_exact;
  end

  assign out_valid  = v_q[STAGES-1];
  assign out_p      = p_q[STAGES-1];
  assign out_tag    = tag_q[STAGES-1];
  assign out_mode   = mode_q[STAGES-1];
  assign adv        = out_ready | ~out_valid;
  assign in_ready   = adv;
  assign hs         = out_valid & out_ready;
  assign cnt_total  = cnt_total_q;
  assign cnt_approx = cnt_approx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        v_q[i]    <= 1'b0;
        p_q[i]    <= '0;
        tag_q[i]  <= '0;
        mode_q[i] <= 1'b0;
      end
      cnt_total_q  <= '0;
      cnt_approx_q <= '0;
    end else begin
      // Whole pipe shifts as one; a bubble carries zeroed payload.
      if (adv) begin
        v_q[0]    <= in_valid;
        p_q[0]    <= in_valid ? p_next : '0;
        tag_q[0]  <= in_valid ? in_tag : '0;
        mode_q[0] <= in_valid & in_mode;
        for (int unsigned i = 1; i < STAGES; i++) begin
          v_q[i]    <= v_q[i-1];
          p_q[i]    <= p_q[i-1];
          tag_q[i]  <= tag_q[i-1];
          mode_q[i] <= mode_q[i-1];
        end
      end
      if (hs && cnt_total_q != '1) begin
        cnt_total_q <= cnt_total_q + 32'd1;
      end
      if (hs && mode_q[STAGES-1] && cnt_approx_q != '1) begin
        cnt_approx_q <= cnt_approx_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Directed bench for approx_mul_pipe: vector table, backpressure, mid-flight reset,
// counter saturation, plus two extra parameterisations checked against a bit-level model.
module tb_approx_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
  logic [7:0]  in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] out_p;
  logic [31:0] cnt_total, cnt_approx;

  logic        x_in_valid, x_in_ready, x_in_mode, x_out_valid, x_out_ready, x_out_mode;
  logic [11:0] x_in_a, x_in_b;
  logic [3:0]  x_in_tag, x_out_tag;
  logic [23:0] x_out_p;
  logic [31:0] x_cnt_total, x_cnt_approx;

  logic        y_in_valid, y_in_ready, y_in_mode, y_out_valid, y_out_ready, y_out_mode;
  logic [3:0]  y_in_a, y_in_b;
  logic [3:0]  y_in_tag, y_out_tag;
  logic [7:0]  y_out_p;
  logic [31:0] y_cnt_total, y_cnt_approx;

  approx_mul_pipe #(.W(8), .TRUNC_K(4), .STAGES(2), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag), .out_mode(out_mode), .cnt_total(cnt_total),
    .cnt_approx(cnt_approx));

  approx_mul_pipe #(.W(12), .TRUNC_K(5), .STAGES(4), .TAG_W(4)) dut_x (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready), .in_a(x_in_a),
    .in_b(x_in_b), .in_mode(x_in_mode), .in_tag(x_in_tag), .out_valid(x_out_valid),
    .out_ready(x_out_ready), .out_p(x_out_p), .out_tag(x_out_tag), .out_mode(x_out_mode),
    .cnt_total(x_cnt_total), .cnt_approx(x_cnt_approx));

  approx_mul_pipe #(.W(4), .TRUNC_K(0), .STAGES(1), .TAG_W(4)) dut_y (
    .clk(clk), .rst(rst), .in_valid(y_in_valid), .in_ready(y_in_ready), .in_a(y_in_a),
    .in_b(y_in_b), .in_mode(y_in_mode), .in_tag(y_in_tag), .out_valid(y_out_valid),
    .out_ready(y_out_ready), .out_p(y_out_p), .out_tag(y_out_tag), .out_mode(y_out_mode),
    .cnt_total(y_cnt_total), .cnt_approx(y_cnt_approx));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        mode;
    logic [3:0]  tag;
    logic [15:0] p;
  } vec_t;

  vec_t vt[8];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Column-wise reference: keep a_i*b_j only where i+j >= k.
  function automatic longint unsigned model(input int w, input int k, input logic mode,
                                            input longint unsigned a, input longint unsigned b);
    longint unsigned acc;
    if (a == 0 || b == 0) return 0;
    if (!mode || k == 0) return a * b;
    acc = 0;
    for (int i = 0; i < w; i++)
      for (int j = 0; j < w; j++)
        if (a[i] && b[j] && (i + j) >= k) acc += longint'(1) << (i + j);
    return acc + (longint'(1) << (k - 1));
  endfunction

  initial begin
    longint unsigned tot_exp, appr_exp;
    logic [15:0] qp[$];
    logic [3:0]  qt[$];
    logic [15:0] held_p;
    logic [3:0]  held_tag;
    logic        stall_prev;
    int          idx, rcv, lat;
    logic [11:0] xa, xb;
    logic [3:0]  ya, yb;
    logic        md;

    vt[0] = '{8'd255, 8'd255, 1'b1, 4'h1, 16'd64984};
    vt[1] = '{8'd3,   8'd5,   1'b1, 4'h2, 16'd8};
    vt[2] = '{8'd16,  8'd16,  1'b1, 4'h3, 16'd264};
    vt[3] = '{8'd0,   8'd200, 1'b1, 4'h4, 16'd0};
    vt[4] = '{8'd3,   8'd5,   1'b0, 4'h5, 16'd15};
    vt[5] = '{8'd1,   8'd1,   1'b1, 4'h6, 16'd8};
    vt[6] = '{8'd255, 8'd1,   1'b1, 4'h7, 16'd248};
    vt[7] = '{8'd200, 8'd100, 1'b0, 4'h8, 16'd20000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0; in_mode = 1'b0; in_tag = '0;
    x_in_valid = 1'b0; x_out_ready = 1'b1; x_in_a = '0; x_in_b = '0; x_in_mode = 1'b0; x_in_tag = '0;
    y_in_valid = 1'b0; y_out_ready = 1'b1; y_in_a = '0; y_in_b = '0; y_in_mode = 1'b0; y_in_tag = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_p", out_p, 0);
    chk("reset_cnt_total", cnt_total, 0);
    chk("reset_in_ready", in_ready, 1);

    // Single exact transaction, latency 2.
    in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255; in_mode = 1'b0; in_tag = 4'hA;
    step();
    in_valid = 1'b0;
    chk("t1_not_early", out_valid, 0);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_p", out_p, 65025);
    chk("t1_tag", out_tag, 4'hA);
    chk("t1_mode", out_mode, 0);
    step();
    chk("t1_cnt_total", cnt_total, 1);
    chk("t1_cnt_approx", cnt_approx, 0);
    chk("t1_drained", out_valid, 0);
    tot_exp = 1; appr_exp = 0;

    // Vector table, back-to-back: vector k appears after step k+1 of the loop.
    for (int c = 0; c < 8 + 2; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_a = vt[c].a; in_b = vt[c].b; in_mode = vt[c].mode; in_tag = vt[c].tag;
        tot_exp++;
        if (vt[c].mode) appr_exp++;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 1 && c - 1 < 8) begin
        chk($sformatf("vec%0d_valid", c - 1), out_valid, 1);
        chk($sformatf("vec%0d_p", c - 1), out_p, vt[c-1].p);
        chk($sformatf("vec%0d_tag", c - 1), out_tag, vt[c-1].tag);
        chk($sformatf("vec%0d_mode", c - 1), out_mode, vt[c-1].mode);
      end
    end
    chk("vec_cnt_total", cnt_total, tot_exp);
    chk("vec_cnt_approx", cnt_approx, appr_exp);

    // Backpressure: stall the consumer for cycles 3..7.
    idx = 0; rcv = 0; stall_prev = 1'b0; held_p = '0; held_tag = '0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      in_valid  = (idx < 6);
      in_a = 8'(20 + 37 * idx); in_b = 8'(201 - 13 * idx); in_mode = idx[0]; in_tag = 4'(9 + idx);
      #1;
      if (out_valid && !out_ready) begin
        chk("bp_in_ready_low", in_ready, 0);
        if (stall_prev) begin
          chk("bp_hold_p", out_p, held_p);
          chk("bp_hold_tag", out_tag, held_tag);
        end
      end
      if (out_valid && out_ready) begin
        if (qp.size() == 0) begin
          chk("bp_unexpected_out", out_valid, 0);
        end else begin
          chk("bp_p", out_p, qp.pop_front());
          chk("bp_tag", out_tag, qt.pop_front());
          rcv++;
        end
      end
      if (in_valid && in_ready) begin
        qp.push_back(16'(model(8, 4, in_mode, 64'(in_a), 64'(in_b))));
        qt.push_back(in_tag);
        if (in_mode) appr_exp++;
        idx++;
      end
      stall_prev = out_valid && !out_ready;
      held_p = out_p; held_tag = out_tag;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_received", rcv, 6);
    tot_exp += 6;
    chk("bp_cnt_total", cnt_total, tot_exp);
    chk("bp_cnt_approx", cnt_approx, appr_exp);
    chk("bp_no_dup", out_valid, 0);

    // Reset with two operations in flight; an input offered during reset is ignored.
    in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255; in_mode = 1'b1; in_tag = 4'hC;
    step();
    in_a = 8'd7; in_b = 8'd9; in_mode = 1'b0; in_tag = 4'hD;
    step();
    rst = 1'b1; in_a = 8'd5; in_b = 8'd5; in_tag = 4'hE;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_cnt_total", cnt_total, 0);
    chk("rst_cnt_approx", cnt_approx, 0);
    chk("rst_in_ready", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rst_no_ghost", out_valid, 0);
    end
    in_valid = 1'b1; in_a = 8'd12; in_b = 8'd11; in_mode = 1'b0; in_tag = 4'h3;
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_p", out_p, 132);
    chk("post_rst_tag", out_tag, 4'h3);
    step();
    chk("post_rst_cnt_total", cnt_total, 1);

    // Saturation: preload both counters one below the ceiling.
    force dut.cnt_total_q = 32'hFFFF_FFFE;
    force dut.cnt_approx_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_total_q;
    release dut.cnt_approx_q;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_a = 8'(c + 2); in_b = 8'd9; in_mode = 1'b1; in_tag = 4'(c);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    chk("sat_cnt_total", cnt_total, 32'hFFFF_FFFF);
    chk("sat_cnt_approx", cnt_approx, 32'hFFFF_FFFF);

    // W=12, K=5, STAGES=4 against the model, including zero and all-ones operands.
    for (int n = 0; n < 8; n++) begin
      xa = (n == 0) ? 12'd0 : (n == 1) ? 12'hFFF : 12'($urandom_range(1, 4095));
      xb = (n == 2) ? 12'd0 : (n == 1) ? 12'hFFF : 12'($urandom_range(1, 4095));
      md = (n < 3) ? 1'b1 : n[0];
      x_in_valid = 1'b1; x_in_a = xa; x_in_b = xb; x_in_mode = md;
      step();
      x_in_valid = 1'b0;
      lat = 1;
      while (!x_out_valid && lat < 12) begin
        step();
        lat++;
      end
      chk("x_latency", lat, 4);
      chk("x_p", x_out_p, model(12, 5, md, 64'(xa), 64'(xb)));
      step();
    end

    // W=4, K=0, STAGES=1: approximate mode must equal exact.
    for (int n = 0; n < 10; n++) begin
      ya = 4'($urandom_range(0, 15));
      yb = (n == 0) ? 4'hF : 4'($urandom_range(0, 15));
      if (n == 0) ya = 4'hF;
      y_in_valid = 1'b1; y_in_a = ya; y_in_b = yb; y_in_mode = n[0];
      step();
      y_in_valid = 1'b0;
      chk("y_latency1_valid", y_out_valid, 1);
      chk("y_p", y_out_p, 64'(ya) * 64'(yb));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
